// File: rtl/ltc2311_sample_averager.sv
// Block averager for the LTC2311 sample stream: sums 2^LOG2_N signed samples,
// shifts down with optional rounding, and holds the result on a valid/ready port.
module ltc2311_sample_averager #(
   parameter int LOG2_N = 4,
   parameter int ROUND  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] sample_in,
   input  logic        sample_valid,
   output logic [15:0] avg_out,
   output logic        avg_valid,
   input  logic        avg_ready,
   output logic        overrun,
   output logic [7:0]  overrun_count,
   input  logic        clear_overrun
);

   localparam int N     = 1 << LOG2_N;
   localparam int AW    = 16 + LOG2_N;
   localparam int SW    = AW + 1;
   localparam int CW    = (LOG2_N > 0) ? LOG2_N : 1;
   localparam int RND_I = (ROUND != 0 && LOG2_N > 0) ? (1 << ((LOG2_N > 0) ? (LOG2_N - 1) : 0)) : 0;

   logic signed [AW-1:0] acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [15:0]          avg_out_q, avg_out_d;
   logic                 avg_valid_q, avg_valid_d;
   logic                 overrun_q, overrun_d;
   logic [7:0]           overrun_count_q, overrun_count_d;

   logic signed [SW-1:0] sum_s;
   logic signed [SW-1:0] shr_s;
   logic [SW-16:0]       hi_s;
   logic [15:0]          result_s;
   logic                 last_s;
   logic                 load_s;
   logic                 accept_s;
   logic                 overwrite_s;

   always_comb begin
      last_s      = (cnt_q == CW'(N - 1));
      load_s      = enable && sample_valid && last_s;
      accept_s    = avg_valid_q && avg_ready;
      overwrite_s = load_s && avg_valid_q && !avg_ready;

      // Guard bit keeps the rounding constant from wrapping near +full-scale
      sum_s = SW'(acc_q) + SW'($signed(sample_in)) + SW'(RND_I);
      shr_s = sum_s >>> LOG2_N;
      hi_s  = shr_s[SW-1:15];
      if ((&hi_s) || !(|hi_s)) begin
         result_s = shr_s[15:0];
      end else begin
         result_s = shr_s[SW-1] ? 16'h8000 : 16'h7FFF;
      end

      if (!enable) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (sample_valid) begin
         if (last_s) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = acc_q + AW'($signed(sample_in));
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end

      if (load_s) begin
         avg_out_d   = result_s;
         avg_valid_d = 1'b1;
      end else if (accept_s) begin
         avg_out_d   = avg_out_q;
         avg_valid_d = 1'b0;
      end else begin
         avg_out_d   = avg_out_q;
         avg_valid_d = avg_valid_q;
      end

      // An overwrite in the same cycle as a clear restarts the count at one
      if (overwrite_s) begin
         overrun_d = 1'b1;
         if (clear_overrun) begin
            overrun_count_d = 8'h01;
         end else if (overrun_count_q == 8'hFF) begin
            overrun_count_d = 8'hFF;
         end else begin
            overrun_count_d = overrun_count_q + 8'h01;
         end
      end else if (clear_overrun) begin
         overrun_d       = 1'b0;
         overrun_count_d = 8'h00;
      end else begin
         overrun_d       = overrun_q;
         overrun_count_d = overrun_count_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q           <= '0;
         cnt_q           <= '0;
         avg_out_q       <= 16'h0000;
         avg_valid_q     <= 1'b0;
         overrun_q       <= 1'b0;
         overrun_count_q <= 8'h00;
      end else begin
         acc_q           <= acc_d;
         cnt_q           <= cnt_d;
         avg_out_q       <= avg_out_d;
         avg_valid_q     <= avg_valid_d;
         overrun_q       <= overrun_d;
         overrun_count_q <= overrun_count_d;
      end
   end

   assign avg_out       = avg_out_q;
   assign avg_valid     = avg_valid_q;
   assign overrun       = overrun_q;
   assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_ltc2311_sample_averager.sv
// Directed bench for ltc2311_sample_averager: five instances with different
// window/rounding settings share one stimulus stream.
`timescale 1ns/1ps
module tb_ltc2311_sample_averager;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [15:0] sample_in = 16'h0000;
   logic        sample_valid = 1'b0;
   logic        avg_ready = 1'b1;
   logic        clear_overrun = 1'b0;

   logic [15:0] out_2r0, out_2r1, out_8r0, out_8r1, out_0;
   logic        val_2r0, val_2r1, val_8r0, val_8r1, val_0;
   logic        ovr_2r0, ovr_2r1, ovr_8r0, ovr_8r1, ovr_0;
   logic [7:0]  cnt_2r0, cnt_2r1, cnt_8r0, cnt_8r1, cnt_0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ltc2311_sample_averager #(.LOG2_N(2), .ROUND(0)) u_2r0 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .avg_out(out_2r0), .avg_valid(val_2r0),
      .avg_ready(avg_ready), .overrun(ovr_2r0), .overrun_count(cnt_2r0),
      .clear_overrun(clear_overrun));
   ltc2311_sample_averager #(.LOG2_N(2), .ROUND(1)) u_2r1 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .avg_out(out_2r1), .avg_valid(val_2r1),
      .avg_ready(avg_ready), .overrun(ovr_2r1), .overrun_count(cnt_2r1),
      .clear_overrun(clear_overrun));
   ltc2311_sample_averager #(.LOG2_N(8), .ROUND(0)) u_8r0 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .avg_out(out_8r0), .avg_valid(val_8r0),
      .avg_ready(avg_ready), .overrun(ovr_8r0), .overrun_count(cnt_8r0),
      .clear_overrun(clear_overrun));
   ltc2311_sample_averager #(.LOG2_N(8), .ROUND(1)) u_8r1 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .avg_out(out_8r1), .avg_valid(val_8r1),
      .avg_ready(avg_ready), .overrun(ovr_8r1), .overrun_count(cnt_8r1),
      .clear_overrun(clear_overrun));
   ltc2311_sample_averager #(.LOG2_N(0), .ROUND(1)) u_0 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .avg_out(out_0), .avg_valid(val_0),
      .avg_ready(avg_ready), .overrun(ovr_0), .overrun_count(cnt_0),
      .clear_overrun(clear_overrun));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one valid sample for one cycle; returns 1 ns after the capturing edge.
   task automatic send(input logic [15:0] x);
      sample_in    = x;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic send_n(input logic [15:0] x, input int n);
      for (int i = 0; i < n; i++) send(x);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] v1 [4];
      v1[0] = 16'h0004; v1[1] = 16'h0008; v1[2] = 16'h000C; v1[3] = 16'h0010;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_out",   out_2r0, 16'h0000);
      chk("rst_valid", {15'h0, val_2r0}, 16'h0000);
      chk("rst_ovr",   {15'h0, ovr_2r0}, 16'h0000);
      chk("rst_cnt",   {8'h00, cnt_2r0}, 16'h0000);
      reset = 1'b0;

      // Basic average 4,8,12,16 -> 10; pass-through instance follows each sample
      avg_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(v1[i]);
         chk("pass_out",   out_0, v1[i]);
         chk("pass_valid", {15'h0, val_0}, 16'h0001);
         if (i < 3) chk("basic_early_valid", {15'h0, val_2r0}, 16'h0000);
      end
      chk("basic_out",   out_2r0, 16'h000A);
      chk("basic_valid", {15'h0, val_2r0}, 16'h0001);
      idle();
      chk("basic_valid_drop", {15'h0, val_2r0}, 16'h0000);

      // Sign and truncation
      pulse_reset();
      send_n(16'hFFFF, 4);
      chk("neg1_r0", out_2r0, 16'hFFFF);
      chk("neg1_r1", out_2r1, 16'hFFFF);
      send_n(16'h0001, 3);
      send(16'h0000);
      chk("trunc_r0", out_2r0, 16'h0000);
      chk("round_r1", out_2r1, 16'h0001);
      send_n(16'hFFFF, 3);
      send(16'h0000);
      chk("negtrunc_r0", out_2r0, 16'hFFFF);
      chk("negtrunc_r1", out_2r1, 16'hFFFF);

      // Extremes over a 256-sample window
      pulse_reset();
      send_n(16'h7FFF, 255);
      chk("max_early_valid", {15'h0, val_8r0}, 16'h0000);
      send(16'h7FFF);
      chk("max_r0",       out_8r0, 16'h7FFF);
      chk("max_r1",       out_8r1, 16'h7FFF);
      chk("max_valid_r1", {15'h0, val_8r1}, 16'h0001);
      send_n(16'h8000, 256);
      chk("min_r0", out_8r0, 16'h8000);
      chk("min_r1", out_8r1, 16'h8000);

      // Overrun with a stalled sink
      pulse_reset();
      avg_ready = 1'b0;
      send_n(16'h0010, 4);
      chk("ovr_first_out", out_2r0, 16'h0010);
      chk("ovr_first_flag", {15'h0, ovr_2r0}, 16'h0000);
      send_n(16'h0020, 4);
      chk("ovr_out",   out_2r0, 16'h0020);
      chk("ovr_flag",  {15'h0, ovr_2r0}, 16'h0001);
      chk("ovr_count", {8'h00, cnt_2r0}, 16'h0001);
      chk("ovr_valid", {15'h0, val_2r0}, 16'h0001);
      avg_ready = 1'b1;
      idle();
      avg_ready = 1'b0;
      chk("ovr_drain_valid", {15'h0, val_2r0}, 16'h0000);
      chk("ovr_drain_flag",  {15'h0, ovr_2r0}, 16'h0001);
      clear_overrun = 1'b1;
      idle();
      clear_overrun = 1'b0;
      chk("clr_flag",  {15'h0, ovr_2r0}, 16'h0000);
      chk("clr_count", {8'h00, cnt_2r0}, 16'h0000);

      // 260 windows into a stalled sink: 259 overwrites, count saturates
      for (int w = 0; w < 260; w++) send_n(16'h0003, 4);
      chk("sat_count", {8'h00, cnt_2r0}, 16'h00FF);

      // Clear coinciding with an overwrite: overwrite wins
      send_n(16'h0004, 3);
      clear_overrun = 1'b1;
      send(16'h0004);
      clear_overrun = 1'b0;
      chk("clrwin_flag",  {15'h0, ovr_2r0}, 16'h0001);
      chk("clrwin_count", {8'h00, cnt_2r0}, 16'h0001);

      // Accept and load in the same cycle
      pulse_reset();
      avg_ready = 1'b0;
      send_n(16'h0010, 4);
      send_n(16'h0020, 3);
      avg_ready = 1'b1;
      send(16'h0020);
      chk("simul_out",   out_2r0, 16'h0020);
      chk("simul_valid", {15'h0, val_2r0}, 16'h0001);
      chk("simul_ovr",   {15'h0, ovr_2r0}, 16'h0000);
      idle();
      chk("simul_drop", {15'h0, val_2r0}, 16'h0000);

      // Back-to-back windows with continuous ready: each result seen once
      for (int w = 1; w <= 3; w++) begin
         send_n(16'(w * 16'h0100), 3);
         chk("b2b_gap_valid", {15'h0, val_2r0}, 16'h0000);
         send(16'(w * 16'h0100));
         chk("b2b_out", out_2r0, 16'(w * 16'h0100));
         chk("b2b_valid", {15'h0, val_2r0}, 16'h0001);
      end
      chk("b2b_ovr", {15'h0, ovr_2r0}, 16'h0000);

      // Flush by enable=0, with an ignored strobe while disabled
      pulse_reset();
      send_n(16'h0100, 2);
      enable       = 1'b0;
      sample_in    = 16'h7000;
      sample_valid = 1'b1;
      idle();
      sample_valid = 1'b0;
      enable       = 1'b1;
      send_n(16'h0010, 3);
      chk("flush_early_valid", {15'h0, val_2r0}, 16'h0000);
      send(16'h0010);
      chk("flush_out", out_2r0, 16'h0010);

      // Flush by reset, with a pending result and overrun beforehand
      avg_ready = 1'b0;
      send_n(16'h0040, 4);
      send_n(16'h0100, 2);
      chk("prerst_ovr", {15'h0, ovr_2r0}, 16'h0001);
      reset        = 1'b1;
      sample_in    = 16'h0100;
      sample_valid = 1'b1;
      idle();
      chk("inrst_out",   out_2r0, 16'h0000);
      chk("inrst_valid", {15'h0, val_2r0}, 16'h0000);
      chk("inrst_ovr",   {15'h0, ovr_2r0}, 16'h0000);
      chk("inrst_cnt",   {8'h00, cnt_2r0}, 16'h0000);
      reset        = 1'b0;
      sample_valid = 1'b0;
      avg_ready    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(16'h0010);
         chk("postrst_out",   out_2r0, 16'h0000);
         chk("postrst_valid", {15'h0, val_2r0}, 16'h0000);
      end
      send(16'h0010);
      chk("rstflush_out",   out_2r0, 16'h0010);
      chk("rstflush_valid", {15'h0, val_2r0}, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
